hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_src_match.sv | 32 +++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults, bypass-select constant and scoreboard entry type for the
// pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned RA_W_DEF       = 5;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned LOAD_STAGE_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 16;

    // Widest register address an entry can carry; narrower addresses are
    // zero-extended on entry so one struct type serves every RA_W.
    localparam int unsigned RA_MAX = 16;

    // Operand select value meaning "take the register file"
    localparam int unsigned BYP_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              we;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Finds the youngest scoreboard stage writing one decode source register and
// reports whether that producer is a load.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W  = RA_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned SEL_W = $clog2(DEPTH_DEF + 1)
) (
    input  logic [RA_W-1:0]  src,
    input  logic             use_src,
    input  sb_entry_t        sb [DEPTH],
    output logic [SEL_W-1:0] sel,
    output logic             hit_load
);

    // Scan oldest to youngest so the last hit (smallest stage) wins; r0 never matches
    always_comb begin
        sel      = SEL_W'(BYP_RF);
        hit_load = 1'b0;
        if (use_src && (src != '0)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (sb[DEPTH-1-i].valid && sb[DEPTH-1-i].we &&
                    (sb[DEPTH-1-i].rd == RA_MAX'(src))) begin
                    sel      = SEL_W'(DEPTH - i);
                    hit_load = sb[DEPTH-1-i].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks post-decode producers, selects bypass
// sources, and raises stall/bubble/flush for load-use, redirect and freeze.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W       = RA_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [RA_W-1:0]            id_rs_a,
    input  logic [RA_W-1:0]            id_rs_b,
    input  logic                       id_use_a,
    input  logic                       id_use_b,
    input  logic [RA_W-1:0]            id_rd,
    input  logic                       id_we,
    input  logic                       id_is_load,
    input  logic                       ex_redirect,
    input  logic                       ext_stall,
    output logic                       stall_f_d,
    output logic                       bubble_x,
    output logic                       flush_f_d,
    output logic [$clog2(DEPTH+1)-1:0] byp_a_sel,
    output logic [$clog2(DEPTH+1)-1:0] byp_b_sel,
    output logic [DEPTH-1:0]           occ,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    // sb[k-1] describes the instruction currently in stage k
    sb_entry_t        sb [DEPTH];
    logic [SEL_W-1:0] a_sel, b_sel;
    logic             a_load, b_load;
    logic             load_use;

    hazard_src_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
        .src      (id_rs_a),
        .use_src  (id_use_a),
        .sb       (sb),
        .sel      (a_sel),
        .hit_load (a_load)
    );

    hazard_src_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
        .src      (id_rs_b),
        .use_src  (id_use_b),
        .sb       (sb),
        .sel      (b_sel),
        .hit_load (b_load)
    );

    // A used source whose youngest producer is a load too early to bypass
    always_comb begin
        load_use = id_valid &&
                   ((a_load && (32'(a_sel) < LOAD_STAGE)) ||
                    (b_load && (32'(b_sel) < LOAD_STAGE)));
    end

    // Control priority: external freeze, then redirect, then load-use
    always_comb begin
        stall_f_d = 1'b0;
        bubble_x  = 1'b0;
        flush_f_d = 1'b0;
        if (ext_stall) begin
            stall_f_d = 1'b1;
        end else if (ex_redirect) begin
            flush_f_d = 1'b1;
            bubble_x  = 1'b1;
        end else if (load_use) begin
            stall_f_d = 1'b1;
            bubble_x  = 1'b1;
        end
        byp_a_sel = a_sel;
        byp_b_sel = b_sel;
    end

    // Expose stage valid bits directly
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ[k] = sb[k].valid;
        end
    end

    // Scoreboard shift and saturating load-use stall counter, on the pipeline's falling edge
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
            stall_count <= '0;
        end else if (!ext_stall) begin
            for (int unsigned k = DEPTH - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            if (id_valid && !bubble_x) begin
                sb[0] <= '{valid: 1'b1, rd: RA_MAX'(id_rd), we: id_we, is_load: id_is_load};
            end else begin
                sb[0] <= '0;
            end
            if (load_use && !ex_redirect && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default build plus a 2-bit
// counter build sharing the same stimulus).
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_use_a, id_use_b, id_we, id_is_load;
    logic [4:0] id_rs_a, id_rs_b, id_rd;
    logic       ex_redirect, ext_stall;

    logic        stall_f_d, bubble_x, flush_f_d;
    logic [1:0]  byp_a_sel, byp_b_sel;
    logic [2:0]  occ;
    logic [15:0] stall_count;

    logic        s2_stall, s2_bubble, s2_flush;
    logic [1:0]  s2_byp_a, s2_byp_b;
    logic [2:0]  s2_occ;
    logic [1:0]  s2_count;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clock = ~clock;

    hazard_ctrl dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .stall_f_d(stall_f_d), .bubble_x(bubble_x), .flush_f_d(flush_f_d),
        .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel), .occ(occ), .stall_count(stall_count)
    );

    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .stall_f_d(s2_stall), .bubble_x(s2_bubble), .flush_f_d(s2_flush),
        .byp_a_sel(s2_byp_a), .byp_b_sel(s2_byp_b), .occ(s2_occ), .stall_count(s2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Decode-stage instruction: sources, destination, load flag
    task automatic dec(input logic v, input logic [4:0] ra, input logic ua,
                       input logic [4:0] rb, input logic ub,
                       input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
        id_rd = rd; id_we = we; id_is_load = ld;
    endtask

    task automatic ctl(input logic s, input logic b, input logic f);
        chk("stall_f_d", 32'(stall_f_d), 32'(s));
        chk("bubble_x",  32'(bubble_x),  32'(b));
        chk("flush_f_d", 32'(flush_f_d), 32'(f));
    endtask

    // Advance through one falling edge, resume just after it
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_redirect = 1'b0; ext_stall = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        // reset state
        ctl(0, 0, 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_byp_a", 32'(byp_a_sel), 0);
        chk("rst_byp_b", 32'(byp_b_sel), 0);
        step();
        reset = 1'b0;

        // add r3, then consumer of r3 in A
        dec(1, 0, 0, 0, 0, 3, 1, 0); #1;
        chk("add_stall", 32'(stall_f_d), 0);
        step();
        dec(1, 3, 1, 0, 0, 4, 1, 0); #1;
        chk("fwd1_byp_a", 32'(byp_a_sel), 1);
        chk("fwd1_occ", 32'(occ), 32'h1);
        ctl(0, 0, 0);
        step();
        dec(1, 3, 1, 0, 0, 0, 0, 0); #1;
        chk("fwd2_byp_a", 32'(byp_a_sel), 2);
        chk("fwd2_stall", 32'(stall_f_d), 0);
        chk("fwd2_occ", 32'(occ), 32'h3);
        step();

        // load r5, then consumer in B: one stall cycle
        dec(1, 0, 0, 0, 0, 5, 1, 1); #1;
        chk("ld_issue_stall", 32'(stall_f_d), 0);
        step();
        dec(1, 0, 0, 5, 1, 6, 1, 0); #1;
        ctl(1, 1, 0);
        chk("lu_cnt_before", 32'(stall_count), 0);
        step();
        #1;
        ctl(0, 0, 0);
        chk("lu_byp_b", 32'(byp_b_sel), 2);
        chk("lu_cnt_after", 32'(stall_count), 1);
        chk("lu_occ", 32'(occ), 32'h6);
        step();

        // r7 in stages 1 and 3, r8 in stage 2
        dec(1, 0, 0, 0, 0, 7, 1, 0); step();
        dec(1, 0, 0, 0, 0, 8, 1, 0); step();
        dec(1, 0, 0, 0, 0, 7, 1, 0); step();
        dec(1, 7, 1, 8, 1, 0, 0, 0); #1;
        chk("young_byp_a", 32'(byp_a_sel), 1);
        chk("young_byp_b", 32'(byp_b_sel), 2);
        chk("young_occ", 32'(occ), 32'h7);
        ctl(0, 0, 0);
        step();

        // stage 1 writes r0; r0 never matches, r7 now in stage 3
        dec(1, 0, 0, 0, 0, 0, 1, 0); step();
        dec(1, 0, 1, 7, 1, 0, 0, 0); #1;
        chk("r0_byp_a", 32'(byp_a_sel), 0);
        chk("r0_byp_b", 32'(byp_b_sel), 3);
        chk("r0_stall", 32'(stall_f_d), 0);
        step();

        // load-use coinciding with redirect
        dec(1, 0, 0, 0, 0, 9, 1, 1); step();
        dec(1, 9, 1, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1; #1;
        ctl(0, 1, 1);
        step();
        ex_redirect = 1'b0;
        chk("redir_cnt", 32'(stall_count), 1);
        chk("redir_occ", 32'(occ), 32'h6);

        // freeze for 4 cycles with a load in stage 1 and a dependent decode
        dec(1, 0, 0, 0, 0, 10, 1, 1); step();
        chk("frz_occ0", 32'(occ), 32'h5);
        dec(1, 10, 1, 0, 0, 0, 0, 0);
        ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            ctl(1, 0, 0);
            chk("frz_occ", 32'(occ), 32'h5);
            chk("frz_cnt", 32'(stall_count), 1);
            step();
        end
        ext_stall = 1'b0; #1;
        ctl(1, 1, 0);
        step();
        chk("frz_cnt_after", 32'(stall_count), 2);

        // three more load-use stalls: 5 total, 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            dec(1, 0, 0, 0, 0, 11, 1, 1); step();
            dec(1, 0, 0, 11, 1, 0, 0, 0); #1;
            chk("sat_stall", 32'(stall_f_d), 1);
            step();
        end
        chk("sat_cnt16", 32'(stall_count), 5);
        chk("sat_cnt2", 32'(s2_count), 3);

        // async reset pulse during a load-use stall
        dec(1, 0, 0, 0, 0, 12, 1, 1); step();
        dec(1, 12, 1, 0, 0, 0, 0, 0); #1;
        chk("prerst_stall", 32'(stall_f_d), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_occ", 32'(occ), 0);
        chk("arst_cnt", 32'(stall_count), 0);
        chk("arst_cnt2", 32'(s2_count), 0);
        chk("arst_stall", 32'(stall_f_d), 0);
        dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
        ctl(0, 0, 0);
        chk("arst_byp_a", 32'(byp_a_sel), 0);
        step();
        reset = 1'b0;

        // first edge after reset behaves normally
        dec(1, 0, 0, 0, 0, 13, 1, 0); step();
        chk("post_occ", 32'(occ), 32'h1);
        dec(1, 13, 1, 0, 0, 0, 0, 0); #1;
        chk("post_byp_a", 32'(byp_a_sel), 1);
        chk("post_cnt", 32'(stall_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
